// File: rtl/seg_display.sv
// Latches a 32-bit value and multiplexes it onto an 8-digit active-low 7-segment display,
// either as hex or as unsigned decimal produced by a serial double-dabble converter.
module seg_display #(
  parameter int DATA_WIDTH = 32,
  parameter int SCAN_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  dec_mode,
  output logic                  busy,
  output logic                  ovf,
  output logic [7:0]            an,
  output logic [7:0]            seg
);

  localparam int BCD_W = 40;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic [BCD_W-1:0]        bcd_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [31:0]             digits_q;
  logic                    ovf_q;
  logic [SCAN_W-1:0]       scan_q;

  logic [BCD_W-1:0]             bcd_adj;
  logic [BCD_W+DATA_WIDTH-1:0]  dd_d;
  logic [2:0]                   sel;
  logic [3:0]                   nibble;
  logic [6:0]                   seg7;

  // Add-3 correction on every BCD nibble that would overflow past 9 after the shift.
  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                            : bcd_q[4*gi +: 4];
  end

  assign dd_d = {bcd_adj, shift_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      scan_q    <= '0;
    end else begin
      scan_q <= scan_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (load) begin
            if (dec_mode) begin
              shift_q   <= din;
              bcd_q     <= '0;
              bit_cnt_q <= '0;
              state_q   <= CONV;
            end else begin
              digits_q <= din;
              ovf_q    <= 1'b0;
            end
          end
        end
        CONV: begin
          {bcd_q, shift_q} <= dd_d;
          bit_cnt_q        <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          digits_q <= bcd_q[31:0];
          ovf_q    <= |bcd_q[39:32];
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign ovf    = ovf_q;
  assign sel    = scan_q[SCAN_W-1 -: 3];
  assign nibble = digits_q[{sel, 2'b00} +: 4];
  assign an     = ~(8'b1 << sel);

  always_comb begin
    seg7 = 7'h7F;
    case (nibble)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  end

  // Decimal point on the most-significant digit flags that upper decimal digits were dropped.
  assign seg = {~((sel == 3'd7) && ovf_q), seg7};

endmodule

// File: tb/tb_seg_display.sv
// Table-driven bench for seg_display with SCAN_W=4 (digit select advances every 2 clocks).
module tb_seg_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] din = '0;
  logic        dec_mode = 1'b0;
  logic        busy;
  logic        ovf;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  seg_display #(.DATA_WIDTH(32), .SCAN_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .din      (din),
    .dec_mode (dec_mode),
    .busy     (busy),
    .ovf      (ovf),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic        dec;
    logic [31:0] exp_digits;
    logic        exp_ovf;
    int          exp_busy;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one load, then count the sampled cycles with busy=1 (bounded).
  task automatic do_load(input logic [31:0] d, input logic dec, output int cycles);
    int n;
    @(negedge clk);
    load = 1'b1; din = d; dec_mode = dec;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    cycles = n;
  endtask

  // Walk the scan to each digit position and compare its segment pattern.
  task automatic check_digits(input logic [31:0] d, input logic o, input string tag);
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    int n;
    for (int s = 0; s < 8; s++) begin
      exp_an = ~(8'b1 << s);
      n = 0;
      while (an !== exp_an && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("%s_an%0d", tag, s), {24'h0, an}, {24'h0, exp_an});
      exp_seg = {~((s == 7) && o), seg_of(d[s*4 +: 4])};
      chk($sformatf("%s_seg%0d", tag, s), {24'h0, seg}, {24'h0, exp_seg});
    end
    chk({tag, "_ovf"}, {31'h0, ovf}, {31'h0, o});
  endtask

  initial begin
    int cyc;
    int cnt;
    logic [3:0] m;

    vecs[0] = '{32'h1234ABCD, 1'b0, 32'h1234ABCD, 1'b0, 0};
    vecs[1] = '{32'd12345678, 1'b1, 32'h12345678, 1'b0, 33};
    vecs[2] = '{32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 0};
    vecs[3] = '{32'd0,        1'b1, 32'h00000000, 1'b0, 33};
    vecs[4] = '{32'd99999999, 1'b1, 32'h99999999, 1'b0, 33};
    vecs[5] = '{32'd100000000,1'b1, 32'h00000000, 1'b1, 33};
    vecs[6] = '{32'hFFFFFFFF, 1'b1, 32'h94967295, 1'b1, 33};

    // Reset values while held in reset.
    #1;
    chk("rst_an",   {24'h0, an},   32'hFE);
    chk("rst_seg",  {24'h0, seg},  32'hC0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovf",  {31'h0, ovf},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an",  {24'h0, an},  32'hFE);
    chk("async_rst_seg", {24'h0, seg}, 32'hC0);
    $display("async reset mid-scan an=%h seg=%h", an, seg);

    // Scan walk and wrap: one anode low per cycle, FE..7F then FE again.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    m = 4'd0;
    for (int i = 0; i <= 32; i++) begin
      chk($sformatf("scan_an_%0d", i), {24'h0, an}, {24'h0, ~(8'b1 << m[3:1])});
      chk($sformatf("scan_onehot_%0d", i), $countones(~an), 32'd1);
      @(negedge clk);
      #1;
      m = m + 4'd1;
    end
    $display("scan walk done, an=%h", an);

    for (int v = 0; v < 7; v++) begin
      do_load(vecs[v].din, vecs[v].dec, cyc);
      chk($sformatf("v%0d_busy_cycles", v), cyc, vecs[v].exp_busy);
      check_digits(vecs[v].exp_digits, vecs[v].exp_ovf, $sformatf("v%0d", v));
      $display("vec %0d din=%h dec=%0d busy_cycles=%0d ovf=%0d", v, vecs[v].din, vecs[v].dec, cyc, ovf);
    end

    // Reset mid-conversion discards the partial result and clears 94967295/ovf.
    @(negedge clk);
    load = 1'b1; din = 32'd12345678; dec_mode = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    chk("midconv_busy_before", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midconv_rst_busy", {31'h0, busy}, 32'h0);
    chk("midconv_rst_ovf",  {31'h0, ovf},  32'h0);
    chk("midconv_rst_an",   {24'h0, an},   32'hFE);
    chk("midconv_rst_seg",  {24'h0, seg},  32'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) chk("midconv_stays_idle", {31'h0, busy}, 32'h0);
    end
    check_digits(32'h0, 1'b0, "midconv");
    $display("reset mid-conversion busy=%0d ovf=%0d", busy, ovf);

    // Load during busy (mid-conversion and on the COMMIT cycle) is ignored.
    @(negedge clk);
    load = 1'b1; din = 32'd5; dec_mode = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 5 || cnt == 33) begin
        load = 1'b1; din = 32'd7; dec_mode = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    chk("ign_busy_cycles", cnt, 32'd33);
    repeat (3) begin
      chk("ign_no_restart", {31'h0, busy}, 32'h0);
      @(negedge clk);
    end
    check_digits(32'h00000005, 1'b0, "ign");
    $display("load-while-busy busy_cycles=%0d", cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
